sopc_bus_ic: RTL

- Parametrised single-master, N-slave memory interconnect for the next-generation minimal SOPC.
- Sits between the core data-memory port (ce/we/addr/sel/data) and N_SLV slaves: data RAM, peripherals, and so on.
- Replaces the hard point-to-point core-to-RAM wiring with:
  - address decode to a slave,
  - a request/ack handshake per slave,
  - a stall back to the core for multi-cycle slaves,
  - timeout and decode-error reporting,
  - pipeline-flush abort.

---
 rtl/sopc_bus_ic_pkg.sv | 20 ++
 rtl/sopc_bus_ic_addr_dec.sv | 27 ++
 rtl/sopc_bus_ic.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sopc_bus_ic_pkg.sv
// Shared types and constants for the SOPC single-master bus interconnect.
// State encoding, bus widths and the default slave map live here.
package sopc_bus_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int REG_BUS_W  = 32;
    localparam int DATA_BUS_W = 32;

    // Default slave map, indexed by the top address nibble
    localparam int SLV_RAM   = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_GPIO  = 2;
    localparam int SLV_TIMER = 3;

endpackage

// File: rtl/sopc_bus_ic_addr_dec.sv
// Combinational address decoder: top DEC_BITS of the address select one slave.
// Indices at or above N_SLV raise dec_err and select nothing.
module sopc_addr_dec #(
    parameter int N_SLV    = 4,
    parameter int AW       = 32,
    parameter int DEC_BITS = 4
) (
    input  logic [AW-1:0]    addr,
    output logic [N_SLV-1:0] sel,
    output logic             dec_err
);

    logic [DEC_BITS-1:0] idx;
    logic                unused_low_bits;

    assign idx             = addr[AW-1 -: DEC_BITS];
    assign unused_low_bits = ^addr[AW-DEC_BITS-1:0];

    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_sel
            assign sel[gi] = (32'(idx) == 32'(gi));
        end
    endgenerate

    assign dec_err = (32'(idx) >= 32'(N_SLV));

endmodule

// File: rtl/sopc_bus_ic.sv
// Single-master, N-slave memory interconnect with per-slave cyc/ack handshake,
// core stall, timeout and decode-error reporting, and flush abort.
module sopc_bus_ic
    import sopc_bus_ic_pkg::*;
#(
    parameter int N_SLV    = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEC_BITS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                m_ce_i,
    input  logic                m_we_i,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW/8-1:0]     m_sel_i,
    input  logic [DW-1:0]       m_data_i,
    output logic [DW-1:0]       m_data_o,
    output logic                m_stall_o,
    output logic                m_err_o,
    output logic [N_SLV-1:0]    s_cyc_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_data_o,
    input  logic [N_SLV*DW-1:0] s_data_i,
    input  logic [N_SLV-1:0]    s_ack_i
);

    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_reg;
    logic [TW-1:0]     timer_reg;
    logic [N_SLV-1:0]  cyc_reg;
    logic              err_reg;
    logic [DW-1:0]     data_reg;
    logic              we_reg;
    logic [AW-1:0]     addr_reg;
    logic [SW-1:0]     sel_reg;
    logic [DW-1:0]     wdata_reg;

    logic [N_SLV-1:0]  dec_sel;
    logic              dec_err;
    logic [DW-1:0]     masked_data [N_SLV];
    logic [DW-1:0]     rd_data;
    logic              ack_hit;
    logic              timeout_hit;

    sopc_addr_dec #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .DEC_BITS (DEC_BITS)
    ) u_addr_dec (
        .addr    (m_addr_i),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    // The one-hot cyc register doubles as the registered slave index
    generate
        for (genvar gi = 0; gi < N_SLV; gi++) begin : g_rd_mux
            assign masked_data[gi] = cyc_reg[gi] ? s_data_i[gi*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_SLV; k++) begin
            rd_data = rd_data | masked_data[k];
        end
    end

    assign ack_hit     = |(s_ack_i & cyc_reg);
    assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            cyc_reg   <= '0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            sel_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    err_reg <= 1'b0;
                    if (m_ce_i && !flush_i) begin
                        we_reg    <= m_we_i;
                        addr_reg  <= m_addr_i;
                        sel_reg   <= m_sel_i;
                        wdata_reg <= m_data_i;
                        timer_reg <= '0;
                        if (dec_err) begin
                            err_reg   <= 1'b1;
                            data_reg  <= '0;
                            state_reg <= ST_DONE;
                        end else begin
                            cyc_reg   <= dec_sel;
                            state_reg <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        cyc_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else if (ack_hit) begin
                        // Ack beats a coincident timeout
                        if (!we_reg) begin
                            data_reg <= rd_data;
                        end
                        cyc_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else if (timeout_hit) begin
                        cyc_reg   <= '0;
                        err_reg   <= 1'b1;
                        data_reg  <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    cyc_reg   <= '0;
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall in IDLE follows the request so the core holds until accepted
    always_comb begin
        m_stall_o = 1'b0;
        case (state_reg)
            ST_IDLE: m_stall_o = m_ce_i & rst_n;
            ST_BUSY: m_stall_o = 1'b1;
            default: m_stall_o = 1'b0;
        endcase
    end

    assign m_err_o  = err_reg;
    assign m_data_o = data_reg;
    assign s_cyc_o  = cyc_reg;
    assign s_we_o   = we_reg;
    assign s_addr_o = addr_reg;
    assign s_sel_o  = sel_reg;
    assign s_data_o = wdata_reg;

endmodule
